// File: rtl/scmp_status_reg.sv
// Status register for the SC/MP-style core: CY/L, OV, IE and F2..F0
// storage, plus two-flop synchronisers for the asynchronous sense pins.
// The status byte is assembled as {CY,OV,SB,SA,IE,F2,F1,F0}.
module scmp_status_reg #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       alu_cy_i,
  input  logic       alu_ov_i,
  input  logic       ld_cy_i,
  input  logic       ld_ov_i,
  input  logic       wr_sr_i,
  input  logic [7:0] wr_data_i,
  input  logic       ien_i,
  input  logic       dint_i,
  input  logic       int_ack_i,
  input  logic       sa_i,
  input  logic       sb_i,
  output logic [7:0] sr_o,
  output logic       cy_o,
  output logic       ov_o,
  output logic [2:0] flag_o,
  output logic       int_req_o
);

  logic                   cy;
  logic                   ov;
  logic                   ie;
  logic [2:0]             flag;
  logic [SYNC_STAGES-1:0] sync_a;
  logic [SYNC_STAGES-1:0] sync_b;
  logic                   sa_s;
  logic                   sb_s;

  // Sense pins shift through the chains; reset flushes anything in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= {sync_a[SYNC_STAGES-2:0], sa_i};
      sync_b <= {sync_b[SYNC_STAGES-2:0], sb_i};
    end
  end

  assign sa_s = sync_a[SYNC_STAGES-1];
  assign sb_s = sync_b[SYNC_STAGES-1];

  // CY/OV: a CAS write overrides the ALU load strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cy <= 1'b0;
      ov <= 1'b0;
    end else if (wr_sr_i) begin
      cy <= wr_data_i[7];
      ov <= wr_data_i[6];
    end else begin
      if (ld_cy_i) cy <= alu_cy_i;
      if (ld_ov_i) ov <= alu_ov_i;
    end
  end

  // User flags change only on a CAS write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag <= 3'b000;
    end else if (wr_sr_i) begin
      flag <= wr_data_i[2:0];
    end
  end

  // IE: acknowledge and DINT clear ahead of a CAS write, which beats IEN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ie <= 1'b0;
    end else if (int_ack_i || dint_i) begin
      ie <= 1'b0;
    end else if (wr_sr_i) begin
      ie <= wr_data_i[3];
    end else if (ien_i) begin
      ie <= 1'b1;
    end
  end

  // Outputs are pure register decodes; no input reaches them combinationally.
  always_comb begin
    sr_o      = {cy, ov, sb_s, sa_s, ie, flag};
    cy_o      = cy;
    ov_o      = ov;
    flag_o    = flag;
    int_req_o = ie & sa_s;
  end

endmodule

// File: tb/tb_scmp_status_reg.sv
module tb_scmp_status_reg;

  logic       clk = 1'b0;
  logic       rst;
  logic       alu_cy_i, alu_ov_i, ld_cy_i, ld_ov_i, wr_sr_i;
  logic [7:0] wr_data_i;
  logic       ien_i, dint_i, int_ack_i, sa_i, sb_i;
  logic [7:0] sr_o;
  logic       cy_o, ov_o, int_req_o;
  logic [2:0] flag_o;

  int vectors = 0;
  int miscompares = 0;

  scmp_status_reg #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst),
    .alu_cy_i(alu_cy_i), .alu_ov_i(alu_ov_i),
    .ld_cy_i(ld_cy_i), .ld_ov_i(ld_ov_i),
    .wr_sr_i(wr_sr_i), .wr_data_i(wr_data_i),
    .ien_i(ien_i), .dint_i(dint_i), .int_ack_i(int_ack_i),
    .sa_i(sa_i), .sb_i(sb_i),
    .sr_o(sr_o), .cy_o(cy_o), .ov_o(ov_o),
    .flag_o(flag_o), .int_req_o(int_req_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    alu_cy_i = 0; alu_ov_i = 0; ld_cy_i = 0; ld_ov_i = 0;
    wr_sr_i = 0; wr_data_i = 8'h00;
    ien_i = 0; dint_i = 0; int_ack_i = 0; sa_i = 0; sb_i = 0;

    #2;
    chk("rst_sr", sr_o, 8'h00);
    chk("rst_int", {7'd0, int_req_o}, 8'h00);
    chk("rst_flag", {5'd0, flag_o}, 8'h00);
    @(negedge clk) rst = 1'b0;

    // CAS write of all ones; sense bits stay 0
    wr_sr_i = 1; wr_data_i = 8'hFF;
    tick;
    chk("cas_sr", sr_o, 8'hCF);
    chk("cas_flag", {5'd0, flag_o}, 8'h07);
    chk("cas_cyov", {6'd0, cy_o, ov_o}, 8'h03);
    chk("cas_int", {7'd0, int_req_o}, 8'h00);
    wr_sr_i = 0;

    repeat (3) tick;
    chk("hold_sr", sr_o, 8'hCF);

    wr_sr_i = 1; wr_data_i = 8'h00;
    tick;
    chk("clear_sr", sr_o, 8'h00);
    wr_sr_i = 0;

    // independent ALU loads
    ld_cy_i = 1; alu_cy_i = 1; ld_ov_i = 0; alu_ov_i = 1;
    tick;
    chk("ldcy_sr", sr_o, 8'h80);
    chk("ldcy_ov", {7'd0, ov_o}, 8'h00);

    wr_sr_i = 1; wr_data_i = 8'h00;
    tick;
    chk("wr_beats_cy", {7'd0, cy_o}, 8'h00);

    wr_sr_i = 0; ld_cy_i = 0; ld_ov_i = 1; alu_ov_i = 1;
    tick;
    chk("ldov_sr", sr_o, 8'h40);

    ld_cy_i = 1; alu_cy_i = 0; ld_ov_i = 1; alu_ov_i = 0;
    wr_sr_i = 1; wr_data_i = 8'hC0;
    tick;
    chk("wr_beats_both", sr_o, 8'hC0);
    ld_cy_i = 0; ld_ov_i = 0;

    // bits 5:4 of the write data are ignored
    wr_data_i = 8'h35;
    tick;
    chk("ignore_54", sr_o, 8'h05);
    chk("flag_5", {5'd0, flag_o}, 8'h05);

    // asynchronous reset between edges with a write held active
    wr_data_i = 8'hFF;
    tick;
    chk("pre_rst", sr_o, 8'hCF);
    rst = 1'b1;
    #1;
    chk("async_rst", sr_o, 8'h00);
    tick;
    chk("rst_ignores_wr", sr_o, 8'h00);
    @(negedge clk) rst = 1'b0;
    tick;
    chk("post_rst_wr", sr_o, 8'hCF);
    wr_sr_i = 0;

    // sense synchronisation latency
    sa_i = 1;
    tick;
    chk("sa_n1", sr_o, 8'hCF);
    tick;
    chk("sa_n2", sr_o, 8'hDF);
    chk("intreq_on", {7'd0, int_req_o}, 8'h01);
    sb_i = 1;
    tick;
    chk("sb_n1", sr_o, 8'hDF);
    tick;
    chk("sb_n2", sr_o, 8'hFF);

    // interrupt enable / disable / acknowledge
    dint_i = 1;
    tick;
    chk("dint_sr", sr_o, 8'hF7);
    chk("dint_int", {7'd0, int_req_o}, 8'h00);
    dint_i = 0; ien_i = 1;
    tick;
    chk("ien_sr", sr_o, 8'hFF);
    chk("ien_int", {7'd0, int_req_o}, 8'h01);
    int_ack_i = 1;
    tick;
    chk("ack_sr", sr_o, 8'hF7);
    chk("ack_int", {7'd0, int_req_o}, 8'h00);
    int_ack_i = 0; ien_i = 0;
    tick;
    chk("ack_hold", {7'd0, int_req_o}, 8'h00);

    // IE priority
    dint_i = 1; wr_sr_i = 1; wr_data_i = 8'h08;
    tick;
    chk("dint_beats_wr", sr_o, 8'h30);
    dint_i = 0; ien_i = 1; wr_data_i = 8'h00;
    tick;
    chk("wr_beats_ien", sr_o, 8'h30);
    ien_i = 0; wr_data_i = 8'h08;
    tick;
    chk("wr_ie", sr_o, 8'h38);
    chk("wr_ie_int", {7'd0, int_req_o}, 8'h01);
    int_ack_i = 1;
    tick;
    chk("ack_beats_wr", sr_o, 8'h30);
    int_ack_i = 0; wr_sr_i = 0;

    // reset discards a sense value in flight
    sa_i = 0; sb_i = 0;
    tick;
    tick;
    chk("sense_low", sr_o, 8'h00);
    ien_i = 1;
    tick;
    chk("ie_set", sr_o, 8'h08);
    ien_i = 0; sa_i = 1;
    tick;
    chk("inflight_n1", sr_o, 8'h08);
    rst = 1'b1; sa_i = 0;
    #1;
    chk("inflight_rst", sr_o, 8'h00);
    @(negedge clk) rst = 1'b0;
    tick;
    chk("flushed_1", sr_o, 8'h00);
    tick;
    chk("flushed_2", sr_o, 8'h00);
    chk("flushed_int", {7'd0, int_req_o}, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
